// File: rtl/extinguisher_sweep_if.sv
// Enable/status bundle between the alarm logic (master) and the nozzle sweeper (slave).
// With EXTINGUISHER_PINGPONG_EN defined the bundle also carries the sweep direction.
interface extinguisher_sweep_if #(
    parameter int POS_W = 3
);
    logic             i_enable;
    logic             o_active;
    logic [POS_W-1:0] o_position;
    logic             o_pass_done;
    logic             o_busy;
`ifdef EXTINGUISHER_PINGPONG_EN
    logic             o_dir;

    modport master (output i_enable, input o_active, input o_position,
                    input o_pass_done, input o_busy, input o_dir);
    modport slave  (input i_enable, output o_active, output o_position,
                    output o_pass_done, output o_busy, output o_dir);
`else
    modport master (output i_enable, input o_active, input o_position,
                    input o_pass_done, input o_busy);
    modport slave  (input i_enable, output o_active, output o_position,
                    output o_pass_done, output o_busy);
`endif
endinterface

// File: rtl/extinguisher_sweep.sv
// Nozzle sweeper: IDLE -> SWEEP (DWELL cycles per position, PASSES passes) -> COOL lockout.
// Optional build macro EXTINGUISHER_PINGPONG_EN selects 0..N-1..1 pass order and adds o_dir.
module extinguisher_sweep #(
    parameter int POS_W   = 3,
    parameter int NUM_POS = 8,
    parameter int DWELL   = 2,
    parameter int PASSES  = 1,
    parameter int COOL    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    extinguisher_sweep_if.slave  sw
);
    localparam int DW_W = $clog2(DWELL + 1);
    localparam int PS_W = (PASSES == 0) ? 1 : $clog2(PASSES + 1);
    localparam int CL_W = (COOL == 0) ? 1 : $clog2(COOL + 1);

    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_POS - 1);
    localparam logic [PS_W-1:0]  PS_TGT   = PS_W'(PASSES);
    localparam logic [CL_W-1:0]  CL_LAST  = CL_W'((COOL == 0) ? 0 : COOL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_active;
    logic [POS_W-1:0] r_position;
    logic             r_pass_done;
    logic             r_busy;
    logic [DW_W-1:0]  r_dwell;
    logic [PS_W-1:0]  r_pass;
    logic [CL_W-1:0]  r_cool;

    logic [POS_W-1:0] w_nxt_pos;
    logic             w_last_dwell;
    logic             w_cur_end;
    logic             w_nxt_end;
    logic [PS_W-1:0]  w_pass_inc;
    logic             w_done_all;
    logic             w_pass_end;

`ifdef EXTINGUISHER_PINGPONG_EN
    logic             r_dir;
    logic             w_nxt_dir;

    // dir drops on arrival at the top position and rises again on the wrap to 0,
    // so "position 1 while descending" uniquely marks the end of a pass.
    always_comb begin
        w_nxt_pos = r_dir ? (r_position + 1'b1) : (r_position - 1'b1);
        w_nxt_dir = r_dir && (w_nxt_pos != POS_LAST);
        w_cur_end = (r_position == POS_W'(1)) && !r_dir;
        w_nxt_end = (w_nxt_pos == POS_W'(1)) && !w_nxt_dir;
    end
`else
    always_comb begin
        w_nxt_pos = r_position + 1'b1;
        w_cur_end = (r_position == POS_LAST);
        w_nxt_end = (w_nxt_pos == POS_LAST);
    end
`endif

    // Pass counter saturates so continuous mode never wraps it.
    always_comb begin
        w_last_dwell = (r_dwell == DW_LAST);
        w_pass_end   = w_last_dwell && w_cur_end;
        w_pass_inc   = (r_pass == {PS_W{1'b1}}) ? r_pass : (r_pass + 1'b1);
        w_done_all   = (PASSES != 0) && (w_pass_inc == PS_TGT);
    end

    // pass_done is registered, so it is computed one cycle ahead from the
    // position/dwell the block is about to enter.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= S_IDLE;
            r_active    <= 1'b0;
            r_position  <= '0;
            r_pass_done <= 1'b0;
            r_busy      <= 1'b0;
            r_dwell     <= '0;
            r_pass      <= '0;
            r_cool      <= '0;
`ifdef EXTINGUISHER_PINGPONG_EN
            r_dir       <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pass_done <= 1'b0;
                    if (sw.i_enable) begin
                        r_state    <= S_SWEEP;
                        r_active   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_position <= '0;
                        r_dwell    <= '0;
                        r_pass     <= '0;
`ifdef EXTINGUISHER_PINGPONG_EN
                        r_dir      <= 1'b1;
`endif
                    end
                end

                S_SWEEP: begin
                    if (!sw.i_enable || (w_pass_end && w_done_all)) begin
                        r_active    <= 1'b0;
                        r_pass_done <= 1'b0;
                        r_dwell     <= '0;
                        r_cool      <= '0;
                        if (COOL == 0) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_position <= '0;
`ifdef EXTINGUISHER_PINGPONG_EN
                            r_dir      <= 1'b1;
`endif
                        end else begin
                            r_state <= S_COOL;
                        end
                    end else if (w_pass_end) begin
                        r_pass      <= w_pass_inc;
                        r_position  <= '0;
                        r_dwell     <= '0;
                        r_pass_done <= 1'b0;
`ifdef EXTINGUISHER_PINGPONG_EN
                        r_dir       <= 1'b1;
`endif
                    end else if (w_last_dwell) begin
                        r_position  <= w_nxt_pos;
                        r_dwell     <= '0;
                        r_pass_done <= (DWELL == 1) && w_nxt_end;
`ifdef EXTINGUISHER_PINGPONG_EN
                        r_dir       <= w_nxt_dir;
`endif
                    end else begin
                        r_dwell     <= r_dwell + 1'b1;
                        r_pass_done <= ((r_dwell + 1'b1) == DW_LAST) && w_cur_end;
                    end
                end

                S_COOL: begin
                    r_pass_done <= 1'b0;
                    if (r_cool == CL_LAST) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_position <= '0;
                        r_cool     <= '0;
`ifdef EXTINGUISHER_PINGPONG_EN
                        r_dir      <= 1'b1;
`endif
                    end else begin
                        r_cool <= r_cool + 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_active    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_pass_done <= 1'b0;
                    r_position  <= '0;
                end
            endcase
        end
    end

    assign sw.o_active    = r_active;
    assign sw.o_position  = r_position;
    assign sw.o_pass_done = r_pass_done;
    assign sw.o_busy      = r_busy;
`ifdef EXTINGUISHER_PINGPONG_EN
    assign sw.o_dir       = r_dir;
`endif

endmodule

// File: tb/tb_extinguisher_sweep.sv
// Directed bench for extinguisher_sweep: one-shot instance (PASSES=1) and continuous instance (PASSES=0).
// Expected outputs are queued as each step is driven and popped after the clock edge.
module tb_extinguisher_sweep;
    localparam int POS_W = 3;

    typedef struct packed {
        logic             act;
        logic [POS_W-1:0] pos;
        logic             pd;
        logic             busy;
    } obs_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    obs_t q_a[$];
    obs_t q_b[$];

    always #5 clk = ~clk;

    extinguisher_sweep_if #(.POS_W(POS_W)) ifa ();
    extinguisher_sweep_if #(.POS_W(POS_W)) ifb ();

    extinguisher_sweep #(.POS_W(POS_W), .NUM_POS(8), .DWELL(2), .PASSES(1), .COOL(4)) u_one (
        .i_clk (clk),
        .i_clr (clr),
        .sw    (ifa)
    );

    extinguisher_sweep #(.POS_W(POS_W), .NUM_POS(8), .DWELL(2), .PASSES(0), .COOL(4)) u_cont (
        .i_clk (clk),
        .i_clr (clr),
        .sw    (ifb)
    );

    function automatic obs_t mk(input logic a, input logic [POS_W-1:0] p, input logic d, input logic b);
        obs_t o;
        o.act  = a;
        o.pos  = p;
        o.pd   = d;
        o.busy = b;
        return o;
    endfunction

    task automatic step_a(input logic en, input logic c, input obs_t exp, input string tag);
        obs_t obs;
        obs_t ref_v;
        ifa.i_enable = en;
        clr          = c;
        q_a.push_back(exp);
        @(posedge clk);
        #1;
        obs   = {ifa.o_active, ifa.o_position, ifa.o_pass_done, ifa.o_busy};
        ref_v = q_a.pop_front();
        checks++;
        assert (obs === ref_v) else begin
            failures++;
            $error("FAIL %s observed act/pos/pd/busy=%b/%0d/%b/%b expected=%b/%0d/%b/%b",
                   tag, obs.act, obs.pos, obs.pd, obs.busy, ref_v.act, ref_v.pos, ref_v.pd, ref_v.busy);
        end
    endtask

    task automatic step_b(input logic en, input obs_t exp, input string tag);
        obs_t obs;
        obs_t ref_v;
        ifb.i_enable = en;
        clr          = 1'b0;
        q_b.push_back(exp);
        @(posedge clk);
        #1;
        obs   = {ifb.o_active, ifb.o_position, ifb.o_pass_done, ifb.o_busy};
        ref_v = q_b.pop_front();
        checks++;
        assert (obs === ref_v) else begin
            failures++;
            $error("FAIL %s observed act/pos/pd/busy=%b/%0d/%b/%b expected=%b/%0d/%b/%b",
                   tag, obs.act, obs.pos, obs.pd, obs.busy, ref_v.act, ref_v.pos, ref_v.pd, ref_v.busy);
        end
    endtask

    initial begin
        ifa.i_enable = 1'b1;
        ifb.i_enable = 1'b0;

        // reset holds everything low even with enable high
        step_a(1'b1, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0), "reset_0");
        step_a(1'b1, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0), "reset_1");

        // full pass, then lockout, idle gap and re-arm
        for (int k = 0; k < 16; k++)
            step_a(1'b1, 1'b0, mk(1'b1, 3'(k / 2), (k == 15), 1'b1), "sweep_pass");
        for (int k = 0; k < 4; k++)
            step_a(1'b1, 1'b0, mk(1'b0, 3'd7, 1'b0, 1'b1), "cool_after_pass");
        step_a(1'b1, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "idle_gap");
        step_a(1'b1, 1'b0, mk(1'b1, 3'd0, 1'b0, 1'b1), "rearm");

        // abort while at position 3
        for (int k = 1; k <= 6; k++)
            step_a(1'b1, 1'b0, mk(1'b1, 3'(k / 2), 1'b0, 1'b1), "sweep_to_3");
        for (int k = 0; k < 4; k++)
            step_a(1'b0, 1'b0, mk(1'b0, 3'd3, 1'b0, 1'b1), "abort_cool");
        step_a(1'b0, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "abort_idle");
        step_a(1'b0, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "idle_stay");

        // clr in the middle of a sweep at position 5
        step_a(1'b1, 1'b0, mk(1'b1, 3'd0, 1'b0, 1'b1), "arm_for_clr");
        for (int k = 1; k <= 10; k++)
            step_a(1'b1, 1'b0, mk(1'b1, 3'(k / 2), 1'b0, 1'b1), "sweep_to_5");
        step_a(1'b1, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0), "mid_clr");
        step_a(1'b0, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "after_clr_idle");

        // abort exactly on the pass-end cycle; enable is ignored during COOL
        step_a(1'b1, 1'b0, mk(1'b1, 3'd0, 1'b0, 1'b1), "arm_pass_end_abort");
        for (int k = 1; k < 16; k++)
            step_a(1'b1, 1'b0, mk(1'b1, 3'(k / 2), (k == 15), 1'b1), "sweep_pass2");
        step_a(1'b0, 1'b0, mk(1'b0, 3'd7, 1'b0, 1'b1), "abort_at_end");
        for (int k = 0; k < 3; k++)
            step_a(1'b1, 1'b0, mk(1'b0, 3'd7, 1'b0, 1'b1), "cool_ignores_en");
        step_a(1'b1, 1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "cool_exit_idle");
        step_a(1'b1, 1'b0, mk(1'b1, 3'd0, 1'b0, 1'b1), "rearm_after_cool");
        step_a(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0), "final_clr");

        // continuous instance: wraps 7->0 with no gap, pass_done every 16 cycles
        ifa.i_enable = 1'b0;
        for (int k = 0; k < 40; k++)
            step_b(1'b1, mk(1'b1, 3'((k / 2) % 8), ((k % 16) == 15), 1'b1), "cont_sweep");
        for (int k = 0; k < 4; k++)
            step_b(1'b0, mk(1'b0, 3'd3, 1'b0, 1'b1), "cont_abort_cool");
        step_b(1'b0, mk(1'b0, 3'd0, 1'b0, 1'b0), "cont_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
